// File: rtl/kypd_scanner_if.sv
// rtl/kypd_scanner_if.sv - key event stream between scanner and consumer
interface kypd_scanner_if #(
  parameter int CODE_W = 4
);
  logic              key_valid;
  logic              key_ready;
  logic [CODE_W-1:0] key_code;
  logic              key_release;

  modport master (output key_valid, key_code, key_release, input key_ready);
  modport slave  (input key_valid, key_code, key_release, output key_ready);
endinterface

// File: rtl/kypd_scanner.sv
// rtl/kypd_scanner.sv - keypad matrix scanner with frame debounce and event FIFO
module kypd_scanner #(
  parameter int NUM_ROWS       = 4,
  parameter int NUM_COLS       = 4,
  parameter int COL_PERIOD     = 100000,
  parameter int SETTLE         = 8,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int CODE_W         = $clog2(NUM_ROWS*NUM_COLS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [NUM_COLS-1:0] col_out,
  kypd_scanner_if.master      key_if,
  output logic                key_held,
  output logic [CODE_W-1:0]   held_code,
  output logic                multi_key,
  output logic                overflow
);
  localparam int NK    = NUM_ROWS*NUM_COLS;
  localparam int CNT_W = (COL_PERIOD > 1) ? $clog2(COL_PERIOD) : 1;
  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int STB_W = $clog2(DEBOUNCE_SCANS+1);
  localparam int EV_W  = CODE_W+1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COL_PERIOD-1);
  localparam logic [CNT_W-1:0] CNT_SMP  = CNT_W'(SETTLE);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS-1);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE_SCANS);
  localparam logic [1:0] ST_NONE  = 2'd0;
  localparam logic [1:0] ST_KEY   = 2'd1;
  localparam logic [1:0] ST_MULTI = 2'd2;

  logic [NUM_ROWS-1:0] row_s1_q, row_s1_d, row_s2_q, row_s2_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [NK-1:0]       frame_q, frame_d;
  logic [1:0]          prev_type_q, prev_type_d, acc_type_q, acc_type_d;
  logic [CODE_W-1:0]   prev_code_q, prev_code_d, acc_code_q, acc_code_d;
  logic [STB_W-1:0]    stable_q, stable_d;
  logic [EV_W-1:0]     mem0_q, mem0_d, mem1_q, mem1_d;
  logic [1:0]          fcnt_q, fcnt_d;
  logic                ovf_q, ovf_d;

  logic              frame_end;
  logic [1:0]        cand_type, nset;
  logic [CODE_W-1:0] cand_code;
  logic              ev_vld [2];
  logic [EV_W-1:0]   ev [2];

  assign frame_end = (cnt_q == CNT_LAST) && (col_q == COL_LAST);

  always_comb begin
    row_s1_d = row_in;
    row_s2_d = row_s1_q;
    cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    col_d    = col_q;
    if (cnt_q == CNT_LAST)
      col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
    frame_d = frame_q;
    if (cnt_q == CNT_SMP) begin
      for (int r = 0; r < NUM_ROWS; r++)
        for (int c = 0; c < NUM_COLS; c++)
          if (COL_W'(c) == col_q) frame_d[r*NUM_COLS+c] = ~row_s2_q[r];
    end
  end

  // Codes of non-KEY candidates are forced to 0 so whole-state compares stay simple.
  always_comb begin
    nset      = 2'd0;
    cand_code = '0;
    for (int i = 0; i < NK; i++) begin
      if (frame_q[i]) begin
        if (nset != 2'd2) nset = nset + 2'd1;
        cand_code = CODE_W'(i);
      end
    end
    cand_type = (nset == 2'd0) ? ST_NONE : (nset == 2'd1) ? ST_KEY : ST_MULTI;
    if (nset != 2'd1) cand_code = '0;
  end

  always_comb begin
    prev_type_d = prev_type_q;
    prev_code_d = prev_code_q;
    stable_d    = stable_q;
    acc_type_d  = acc_type_q;
    acc_code_d  = acc_code_q;
    for (int i = 0; i < 2; i++) begin
      ev_vld[i] = 1'b0;
      ev[i]     = '0;
    end
    if (frame_end) begin
      if ({cand_type, cand_code} == {prev_type_q, prev_code_q})
        stable_d = (stable_q == STB_MAX) ? stable_q : stable_q + 1'b1;
      else
        stable_d = STB_W'(1);
      prev_type_d = cand_type;
      prev_code_d = cand_code;
      if (stable_d == STB_MAX && {cand_type, cand_code} != {acc_type_q, acc_code_q}) begin
        acc_type_d = cand_type;
        acc_code_d = cand_code;
        if (acc_type_q == ST_KEY) begin
          ev_vld[0] = 1'b1;
          ev[0]     = {1'b1, acc_code_q};
        end
        if (cand_type == ST_KEY) begin
          if (ev_vld[0]) begin
            ev_vld[1] = 1'b1;
            ev[1]     = {1'b0, cand_code};
          end else begin
            ev_vld[0] = 1'b1;
            ev[0]     = {1'b0, cand_code};
          end
        end
      end
    end
  end

  // Pop first so a same-cycle pop frees a slot for the incoming event(s).
  always_comb begin
    mem0_d = mem0_q;
    mem1_d = mem1_q;
    fcnt_d = fcnt_q;
    ovf_d  = 1'b0;
    if (fcnt_q != 2'd0 && key_if.key_ready) begin
      mem0_d = mem1_q;
      fcnt_d = fcnt_q - 2'd1;
    end
    for (int i = 0; i < 2; i++) begin
      if (ev_vld[i]) begin
        if (fcnt_d == 2'd0) begin
          mem0_d = ev[i];
          fcnt_d = 2'd1;
        end else if (fcnt_d == 2'd1) begin
          mem1_d = ev[i];
          fcnt_d = 2'd2;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1_q    <= '1;
      row_s2_q    <= '1;
      cnt_q       <= '0;
      col_q       <= '0;
      frame_q     <= '0;
      prev_type_q <= ST_NONE;
      prev_code_q <= '0;
      stable_q    <= '0;
      acc_type_q  <= ST_NONE;
      acc_code_q  <= '0;
      mem0_q      <= '0;
      mem1_q      <= '0;
      fcnt_q      <= 2'd0;
      ovf_q       <= 1'b0;
    end else begin
      row_s1_q    <= row_s1_d;
      row_s2_q    <= row_s2_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      frame_q     <= frame_d;
      prev_type_q <= prev_type_d;
      prev_code_q <= prev_code_d;
      stable_q    <= stable_d;
      acc_type_q  <= acc_type_d;
      acc_code_q  <= acc_code_d;
      mem0_q      <= mem0_d;
      mem1_q      <= mem1_d;
      fcnt_q      <= fcnt_d;
      ovf_q       <= ovf_d;
    end
  end

  assign col_out            = ~(NUM_COLS'(1) << col_q);
  assign key_if.key_valid   = (fcnt_q != 2'd0);
  assign key_if.key_code    = mem0_q[CODE_W-1:0];
  assign key_if.key_release = mem0_q[CODE_W];
  assign key_held           = (acc_type_q == ST_KEY);
  assign held_code          = acc_code_q;
  assign multi_key          = (acc_type_q == ST_MULTI);
  assign overflow           = ovf_q;
endmodule

// File: tb/tb_kypd_scanner.sv
// tb/tb_kypd_scanner.sv - scoreboard bench for kypd_scanner
module tb_kypd_scanner;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       key_held, multi_key, overflow;
  logic [3:0] held_code;
  logic [15:0] pressed;

  int compared   = 0;
  int mismatched = 0;
  int ovf_cnt    = 0;
  logic [4:0] exp_q [$];

  kypd_scanner_if #(.CODE_W(4)) kif ();

  kypd_scanner #(
    .NUM_ROWS(4), .NUM_COLS(4), .COL_PERIOD(16), .SETTLE(4), .DEBOUNCE_SCANS(3), .CODE_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .row_in(row_in), .col_out(col_out), .key_if(kif.master),
    .key_held(key_held), .held_code(held_code), .multi_key(multi_key), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a row reads low when a pressed key sits on the driven column.
  always_comb begin
    row_in = '1;
    for (int r = 0; r < 4; r++)
      row_in[r] = ~|(pressed[r*4 +: 4] & ~col_out);
  end

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && overflow) ovf_cnt++;
    if (rst_n && kif.key_valid && kif.key_ready) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_event: got rel=%0d code=%0d expected none", kif.key_release, kif.key_code);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        if ({kif.key_release, kif.key_code} != e) begin
          mismatched++;
          $display("FAIL event: got rel=%0d code=%0d expected rel=%0d code=%0d",
                   kif.key_release, kif.key_code, e[4], e[3:0]);
        end
      end
    end
  end

  task automatic sync_frame();
    logic [3:0] prev;
    int n;
    prev = col_out;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (prev == 4'b0111 && col_out == 4'b1110) break;
      prev = col_out;
      if (n > 200) begin
        compared++;
        mismatched++;
        $display("FAIL frame_sync: got timeout expected frame boundary");
        break;
      end
    end
  endtask

  task automatic wait_frames(input int k);
    repeat (k) sync_frame();
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 kif.key_ready = v;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] prev;
    rst_n = 1'b0;
    kif.key_ready = 1'b1;
    pressed = '0;
    repeat (3) @(negedge clk);
    chk("rst_col_out", col_out, 4'b1110);
    chk("rst_valid", kif.key_valid, 0);
    chk("rst_code", kif.key_code, 0);
    rst_n = 1'b1;

    // Idle column rotation
    repeat (8) @(negedge clk);
    chk("idle_col0", col_out, 4'b1110);
    repeat (16) @(negedge clk);
    chk("idle_col1", col_out, 4'b1101);
    repeat (16) @(negedge clk);
    chk("idle_col2", col_out, 4'b1011);
    repeat (16) @(negedge clk);
    chk("idle_col3", col_out, 4'b0111);
    chk("idle_status", {key_held, multi_key, overflow, held_code}, 0);

    // Single press of code 6 with latency check
    sync_frame();
    pressed[6] = 1'b1;
    exp_q.push_back({1'b0, 4'd6});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!kif.key_valid && n < 400);
    chk("press_latency", n, 192);
    chk("press_held", key_held, 1);
    chk("press_held_code", held_code, 6);
    wait_frames(2);
    pressed = '0;
    exp_q.push_back({1'b1, 4'd6});
    wait_frames(4);
    chk("release_held", key_held, 0);
    chk("release_held_code", held_code, 0);

    // Bounce rejection on code 5
    for (int f = 0; f < 6; f++) begin
      pressed[5] = (f % 2 == 0);
      sync_frame();
    end
    chk("bounce_no_hold", key_held, 0);
    pressed[5] = 1'b1;
    exp_q.push_back({1'b0, 4'd5});
    wait_frames(4);
    chk("bounce_held_code", held_code, 5);
    pressed = '0;
    exp_q.push_back({1'b1, 4'd5});
    wait_frames(4);

    // Direct change 6 -> 9 and overflow with consumer stalled
    pressed[6] = 1'b1;
    exp_q.push_back({1'b0, 4'd6});
    wait_frames(4);
    set_ready(1'b0);
    sync_frame();
    pressed = '0;
    pressed[9] = 1'b1;
    exp_q.push_back({1'b1, 4'd6});
    exp_q.push_back({1'b0, 4'd9});
    wait_frames(4);
    chk("full_valid", kif.key_valid, 1);
    chk("full_head_rel", kif.key_release, 1);
    chk("full_head_code", kif.key_code, 6);
    chk("full_held_code", held_code, 9);
    ovf_cnt = 0;
    pressed = '0;
    wait_frames(4);
    chk("overflow_pulses", ovf_cnt, 1);
    chk("ovf_held", key_held, 0);
    set_ready(1'b1);
    repeat (4) @(negedge clk);
    chk("drain_valid", kif.key_valid, 0);

    // Multi-key: 1 and 6 together, then drop 1
    sync_frame();
    pressed[1] = 1'b1;
    pressed[6] = 1'b1;
    wait_frames(4);
    chk("multi_set", multi_key, 1);
    chk("multi_no_held", key_held, 0);
    pressed[1] = 1'b0;
    exp_q.push_back({1'b0, 4'd6});
    wait_frames(4);
    chk("multi_clear", multi_key, 0);
    chk("multi_held_code", held_code, 6);

    // Reset mid-handshake while an event is pending
    set_ready(1'b0);
    sync_frame();
    pressed = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!kif.key_valid && n < 400);
    chk("pending_valid", kif.key_valid, 1);
    pressed[6] = 1'b1;
    prev = col_out;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (col_out == prev && n < 40);
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", kif.key_valid, 0);
    chk("arst_col_out", col_out, 4'b1110);
    chk("arst_status", {key_held, multi_key, overflow, held_code, kif.key_release, kif.key_code}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    set_ready(1'b1);
    exp_q.push_back({1'b0, 4'd6});
    wait_frames(5);
    chk("post_rst_held", key_held, 1);
    chk("post_rst_code", held_code, 6);
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/kypd_scanner.md
Name: kypd_scanner

Overview:
- Parametrised keypad matrix scanner: next generation of the fixed 4x4 PmodKYPD decoder.
- Drives one column low at a time and samples the synchronised rows once per column slot.
- Debounces whole scan frames and emits press and release events through a 2-entry valid/ready FIFO. Also reports held-key and multi-key status.
- Sits between the keypad pins and the calculator input logic. Maps row/column to a raw index; key legends are mapped downstream.

Parameters:
- NUM_ROWS, 4, number of row inputs.
- NUM_COLS, 4, number of column outputs.
- COL_PERIOD, 100000, clk cycles per column slot (1 ms at 100 MHz).
- SETTLE, 8, cycle within the slot at which rows are sampled. Constraint: 3 <= SETTLE < COL_PERIOD.
- DEBOUNCE_SCANS, 3, number of consecutive identical frames required to accept a new state. Must be >= 1.
- CODE_W, clog2(NUM_ROWS*NUM_COLS), key code width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- row_in  in  NUM_ROWS  keypad rows, active-low (0 = pressed), asynchronous to clk
- col_out  out  NUM_COLS  column drive, active-low one-cold
- key_valid  out  1  event FIFO non-empty
- key_ready  in  1  consumer accepts head event when key_valid && key_ready
- key_code  out  CODE_W  head event code = r*NUM_COLS + c
- key_release  out  1  head event type: 0 = press, 1 = release
- key_held  out  1  a single debounced key is currently held
- held_code  out  CODE_W  code of held key; 0 when none held
- multi_key  out  1  debounced state is two or more keys
- overflow  out  1  one-cycle pulse when an event is dropped because the FIFO is full

Behaviour:
- Reset (async assert, sync release): col index c=0, slot counter cnt=0, col_out = ~1 (column 0 low). FIFO empty, key_valid=0, key_code=0, key_release=0. key_held=0, held_code=0, multi_key=0, overflow=0. Accepted state = NONE, previous candidate = NONE, stable count = 0.
- row_in passes through a 2-FF synchroniser. Samples always use the synchronised value.
- Scan: cnt counts 0..COL_PERIOD-1 in each slot.
  - When cnt==SETTLE, the inverted synced rows are stored into frame bits [r][c].
  - When cnt==COL_PERIOD-1, c advances (wrapping NUM_COLS-1 -> 0) and col_out updates on the same edge.
- Frame end = the cycle with cnt==COL_PERIOD-1 and c==NUM_COLS-1. Candidate classification:
  - zero bits set -> NONE;
  - exactly one bit set -> KEY(code);
  - two or more bits set -> MULTI.
- Debounce, evaluated at each frame end:
  - If candidate == previous candidate, stable count increments, saturating at DEBOUNCE_SCANS. Otherwise stable count = 1.
  - Previous candidate <= candidate.
  - When stable count reaches DEBOUNCE_SCANS and candidate != accepted state, the accepted state updates and events are generated. Accepted state and status outputs change on the edge ending the frame-end cycle.
- Event generation on an accepted transition:
  - NONE -> KEY(k): push press k.
  - KEY(k) -> NONE: push release k.
  - KEY(k) -> KEY(j): push release k, then press j, in that order, in the same cycle.
  - Any -> MULTI: push release k if KEY(k) was held; multi_key=1, key_held=0.
  - MULTI -> KEY(j): multi_key=0, push press j.
  - MULTI -> NONE: multi_key=0, no event.
- Latency: key_valid rises in the cycle after the accepting frame-end cycle. FIFO is show-ahead: key_code and key_release are valid whenever key_valid=1.
- FIFO: 2 entries, ordered.
  - Pop on key_valid && key_ready.
  - A pop and a push in the same cycle are both honoured.
  - A push to a full FIFO (after any same-cycle pop) is dropped and overflow pulses for 1 cycle.
  - For a double push with one free slot: the first event is stored, the second is dropped, and overflow pulses.
- key_held, held_code and multi_key are levels. They reflect the accepted state independent of FIFO occupancy.
- A reset asserted mid-scan or mid-handshake clears everything immediately, including pending events and debounce history.

Test Plan:
Bench parameters: NUM_ROWS=4, NUM_COLS=4, COL_PERIOD=16, SETTLE=4, DEBOUNCE_SCANS=3, key_ready=1 unless stated. One frame = 64 cycles.
- Reset/idle: hold rst_n=0 then release with no keys -> col_out=1110 and rotates 1101, 1011, 0111 every 16 cycles; key_valid never asserts; all status outputs 0.
- Single press: hold row1 low while col2 is driven for 5 frames, then release -> exactly one press code=6 one cycle after the 3rd stable frame end; key_held=1, held_code=6. Then exactly one release code=6 after 3 empty frames; held_code returns to 0.
- Bounce rejection: press pattern present/absent on alternating frames for 6 frames -> no events. Then 3 stable pressed frames -> one press event.
- Direct change and overflow with key_ready=0: code 6 held, then switch directly to code 9 -> FIFO holds release 6 then press 9 and stays full. Then release 9 -> overflow pulses once. With key_ready=1 the pops deliver release 6, then press 9, then key_valid=0.
- Multi-key: press codes 1 and 6 together from idle -> multi_key=1 after 3 frames with no events. Drop code 1 -> multi_key=0 and press 6 is emitted after 3 frames.
- Reset mid-operation: assert rst_n=0 while key_valid=1 and cnt=7 -> all outputs return to reset values asynchronously. After release the FIFO is empty and a still-held key is re-debounced and reported as a fresh press.
